// File: rtl/pipelined_adder_sub.sv
// -----------------------------------------------------------------------------
// pipelined_adder_sub
//
// Pipelined WIDTH-bit adder/subtractor. The operands are split into CHUNK-bit
// slices. Each slice has one register stage, so the carry moves up one slice
// per clock cycle.
//
// Each stage carries three things alongside it in skewed registers:
//   - the operand bits that have not been processed yet,
//   - the sum bits that are already finished,
//   - the carry out of the slice it just resolved.
//
// The final stage register drives Sum/Cout/Ovf directly.
// A single global stall (out_valid & ~out_ready) freezes every stage.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   CHUNK  bits resolved per stage (1..WIDTH); STAGES = ceil(WIDTH/CHUNK)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when high (independent of in_valid)
//   A, B       operands
//   Cin        carry-in (borrow-in when Sub=1)
//   Sub        0: A+B+Cin, 1: A-B-Cin
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   Sum        result modulo 2^WIDTH (saturated on overflow when enabled)
//   Cout       carry-out (Sub=1: 1 means no borrow)
//   Ovf        two's-complement signed overflow
//
// Optional build macro:
//   PIPELINED_ADDER_SAT_EN  when defined, Sum saturates to the signed
//                           max/min on overflow (Cout/Ovf unchanged).
// -----------------------------------------------------------------------------
module pipelined_adder_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST   = STAGES - 1;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Ripple full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Stage registers (index k = stage k)
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  // Stage inputs. The a/b/v inputs load into the registers as they are.
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             cin_w [STAGES];

  // Stage results
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];
  logic             msb_d [STAGES];
  logic             ovf_d;

  logic             stall;

  // Global stall: a result is waiting and downstream refuses it.
  assign stall    = v_q[LAST] & ~out_ready;
  assign in_ready = ~stall;

  // Stage 0 takes its inputs from the ports. Subtraction is done as
  // A + ~B + ~Cin, so Cout=1 means "no borrow".
  assign a_d[0]   = A;
  assign b_d[0]   = Sub ? ~B : B;
  assign cin_w[0] = Sub ? ~Cin : Cin;
  assign s_in[0]  = '0;
  assign v_d[0]   = in_valid;

  genvar gi;

  // Each later stage takes its inputs from the previous stage's registers.
  for (gi = 1; gi < STAGES; gi++) begin : g_link
    assign a_d[gi]   = a_q[gi-1];
    assign b_d[gi]   = b_q[gi-1];
    assign cin_w[gi] = c_q[gi-1];
    assign s_in[gi]  = s_q[gi-1];
    assign v_d[gi]   = v_q[gi-1];
  end

  // Per-stage slice adder. Bits outside the slice pass through unchanged.
  for (gi = 0; gi < STAGES; gi++) begin : g_slice
    localparam int LO = gi * CHUNK;
    localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH : LO + CHUNK;

    logic [WIDTH-1:0] sum_bits;
    logic             cy_out;
    logic             msb_cy;

    always_comb begin
      logic       cy;
      logic [1:0] fa;

      sum_bits = s_in[gi];
      cy       = cin_w[gi];
      msb_cy   = cin_w[gi];
      fa       = '0;

      for (int i = LO; i < HI; i++) begin
        // The carry into the MSB is needed for the signed-overflow flag.
        if (i == WIDTH - 1) begin
          msb_cy = cy;
        end
        fa          = full_adder(a_d[gi][i], b_d[gi][i], cy);
        sum_bits[i] = fa[0];
        cy          = fa[1];
      end

      cy_out = cy;
    end

    assign c_d[gi]   = cy_out;
    assign msb_d[gi] = msb_cy;

    if (gi == LAST) begin : g_final
`ifdef PIPELINED_ADDER_SAT_EN
      // On overflow the wrapped MSB is the opposite of the true sign:
      // a wrapped MSB of 1 means the true result was positive.
      assign s_d[gi] = ovf_d ? (sum_bits[WIDTH-1] ? SAT_MAX : SAT_MIN) : sum_bits;
`else
      assign s_d[gi] = sum_bits;
`endif
    end else begin : g_mid
      assign s_d[gi] = sum_bits;
    end
  end

  assign ovf_d = msb_d[LAST] ^ c_d[LAST];

  // Pipeline registers. Every stage holds during a stall, so bubbles stay
  // where they are. Reset flushes all in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign Sum       = s_q[LAST];
  assign Cout      = c_q[LAST];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
`timescale 1ns/1ps
module tb_pipelined_adder_sub;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int ST = (W + CH - 1) / CH;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 16-bit DUT signals
  logic         in_valid;
  logic         in_ready;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic         cout;
  logic         ovf;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;

  // 1-bit DUT signals
  logic in_valid1;
  logic in_ready1;
  logic a1;
  logic b1;
  logic cin1;
  logic sub1;
  logic out_valid1;
  logic out_ready1;
  logic sum1;
  logic cout1;
  logic ovf1;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_rdy = 0;

  exp_t q16[$];
  exp_t q1[$];

  pipelined_adder_sub #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  pipelined_adder_sub #(.WIDTH(1), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int w, input longint av, input longint bv,
                                 input bit cv, input bit sv);
    longint m, half, sa, sb, ru, rs, s, c;
    bit     co, ov;
    exp_t   e;

    m    = longint'(1) << w;
    half = m / 2;
    c    = cv ? 1 : 0;
    sa   = (av >= half) ? av - m : av;
    sb   = (bv >= half) ? bv - m : bv;

    if (sv) begin
      ru = av - bv - c;
      rs = sa - sb - c;
      co = (ru >= 0);
    end else begin
      ru = av + bv + c;
      rs = sa + sb + c;
      co = (ru >= m);
    end

    s  = ru & (m - 1);
    ov = (rs >= half) || (rs < -half);
`ifdef PIPELINED_ADDER_SAT_EN
    if (ov) s = (rs > 0) ? half - 1 : half;
`endif

    e.sum  = s[15:0];
    e.cout = co;
    e.ovf  = ov;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Accept monitor: push the expected result for every accepted beat.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) q16.push_back(model(W, longint'(a), longint'(b), cin, sub));
    if (rst_n && in_valid1 && in_ready1) q1.push_back(model(1, longint'(a1), longint'(b1), cin1, sub1));
  end

  // Output monitor for the 16-bit DUT: scoreboard pop plus stall-freeze checks.
  logic        held16 = 1'b0;
  logic [17:0] held_val16;
  int          beat16 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held16 = 1'b0;
    end else begin
      if (held16) chk("stall_hold16", {out_valid, sum, cout, ovf}, {1'b1, held_val16});
      if (out_valid && !out_ready) begin
        chk("stall_in_ready16", in_ready, 0);
        held16     = 1'b1;
        held_val16 = {sum, cout, ovf};
      end else begin
        held16 = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out16: got sum=%h with empty queue, required no beat", sum);
        end else begin
          e = q16.pop_front();
          beat16++;
          $display("beat16 %0d: sum=%h cout=%b ovf=%b exp=%h/%b/%b", beat16, sum, cout, ovf,
                   e.sum, e.cout, e.ovf);
          chk("result16", {sum, cout, ovf}, e);
        end
      end
    end
  end

  // Output monitor for the 1-bit DUT.
  int beat1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out1: got sum=%b with empty queue, required no beat", sum1);
      end else begin
        e = q1.pop_front();
        beat1++;
        $display("beat1 %0d: sum=%b cout=%b ovf=%b exp=%b/%b/%b", beat1, sum1, cout1, ovf1,
                 e.sum[0], e.cout, e.ovf);
        chk("result1", {15'd0, sum1, cout1, ovf1}, e);
      end
    end
  end

  // Random back-pressure.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send16_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic av, input logic bv, input logic cv, input logic sv);
    bit ok;
    ok        = 0;
    in_valid1 = 1'b1;
    a1        = av;
    b1        = bv;
    cin1      = cv;
    sub1      = sv;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send1_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic drain16();
    for (int t = 0; t < 2000 && q16.size() != 0; t++) @(negedge clk);
    chk("drain16_empty", q16.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return r;
    endcase
  endfunction

  task automatic latency16(input int req);
    int n;
    n = 0;
    for (int t = 1; t <= 20 && n == 0; t++) begin
      @(negedge clk);
      if (out_valid) n = t;
    end
    chk("latency16", n, req);
  endtask

  initial begin
    int n;
    in_valid   = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
    in_valid1  = 0; a1 = 0;  b1 = 0;  cin1 = 0; sub1 = 0; out_ready1 = 1;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state16", {out_valid, sum, cout, ovf}, 0);
    chk("reset_state1", {out_valid1, sum1, cout1, ovf1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {in_ready, in_ready1}, 2'b11);

    // Directed beats, each checked for latency as well as value.
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0); latency16(ST); drain16();
    send16(16'h0005, 16'h0007, 1'b0, 1'b1); latency16(ST); drain16();
    send16(16'h0005, 16'h0007, 1'b1, 1'b1); drain16();
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain16();
    send16(16'h8000, 16'h0001, 1'b0, 1'b1); drain16();

    // Eight back-to-back beats, with out_ready dropped for three edges mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send16(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain16();

    // Random stream with bubbles and random back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send16(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain16();

    // Reset with beats in flight: out_valid drops asynchronously and no stale beat appears.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send16(pick(), pick(), 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", {out_valid, sum, cout, ovf}, 0);
    q16.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("post_reset_quiet", n, 0);
    @(posedge clk);
    #1;
    send16(16'h1234, 16'h4321, 1'b1, 1'b0); latency16(ST); drain16();

    // 1-bit degenerate instance: full-adder truth table, then subtraction.
    send1(1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int t = 1; t <= 20 && n == 0; t++) begin
      @(negedge clk);
      if (out_valid1) n = t;
    end
    chk("latency1", n, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send1(v[2], v[1], v[0], v[3]);
    end
    for (int t = 0; t < 50 && q1.size() != 0; t++) @(negedge clk);
    chk("drain1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
